// File: rtl/cpu_bram.sv
// cpu_bram: single-port synchronous block RAM with a fixed one-cycle registered read.
// Reset clears only the output registers; the storage array keeps its contents.
module cpu_bram #(
  parameter int WIDTH    = 32,
  parameter int SIZE     = 1024,
  parameter int ADDR_LSH = 2
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_request,
  input  logic             i_rw,
  input  logic [31:0]      i_address,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_ready,
  output logic             o_valid
);
  localparam int AW = $clog2(SIZE);
  logic [WIDTH-1:0] mem [SIZE] = '{default: '0};
  logic [AW-1:0]    idx;
  logic             in_range, rd, wr;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             ready_q, ready_d, valid_q, valid_d;
  assign idx      = AW'(i_address >> ADDR_LSH);
  // Only a non-power-of-two SIZE can produce an index past the last word.
  assign in_range = 32'(idx) < 32'(SIZE);
  assign rd       = i_request && !i_rw;
  assign wr       = i_request && i_rw && in_range;
  always_comb begin
    rdata_d = rd ? (in_range ? mem[idx] : '0) : rdata_q;
    ready_d = i_request;
    valid_d = rd;
  end
  // Memory shares the reset branch so an access landing on an asserted reset is dropped.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      rdata_q <= '0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      if (wr) mem[idx] <= i_wdata;
    end
  end
  assign o_rdata = rdata_q;
  assign o_ready = ready_q;
  assign o_valid = valid_q;
endmodule

// File: tb/tb_cpu_bram.sv
// tb_cpu_bram: directed vectors with hand-computed responses, checked by a queue-based monitor.
// DUT: 64-bit words, 1000 words (non-power-of-two, AW=10), byte addressing (ADDR_LSH=2).
module tb_cpu_bram;
  typedef struct {
    string       name;
    logic        rdy;
    logic        vld;
    logic [63:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req = 1'b0;
  logic        rw = 1'b0;
  logic [31:0] addr = '0;
  logic [63:0] wdata = '0;
  logic [63:0] rdata;
  logic        ready, valid;
  exp_t        q[$];
  int          n_chk = 0;
  int          n_fail = 0;

  cpu_bram #(.WIDTH(64), .SIZE(1000), .ADDR_LSH(2)) dut (
    .i_clock(clk), .i_reset(rst), .i_request(req), .i_rw(rw),
    .i_address(addr), .i_wdata(wdata),
    .o_rdata(rdata), .o_ready(ready), .o_valid(valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string name, input logic r, input logic v, input logic [63:0] d);
    chk({name, ".ready"}, {63'd0, ready}, {63'd0, r});
    chk({name, ".valid"}, {63'd0, valid}, {63'd0, v});
    chk({name, ".rdata"}, rdata, d);
  endtask

  // Drive one access, let the edge happen, then queue the hand-computed response.
  task automatic cyc(input string name, input logic rq, input logic w, input logic [31:0] a,
                     input logic [63:0] wd, input logic r, input logic v, input logic [63:0] d);
    exp_t e;
    req = rq; rw = w; addr = a; wdata = wd;
    @(posedge clk);
    #1;
    e.name = name; e.rdy = r; e.vld = v; e.data = d;
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk_out(e.name, e.rdy, e.vld, e.data);
      end
    end
  end

  initial begin : stim
    #1 rst = 1'b1;
    #1 chk_out("por", 1'b0, 1'b0, 64'h0);
    #10 rst = 1'b0;
    cyc("idle0", 0, 0, 32'h0,   64'h0, 0, 0, 64'h0);
    cyc("idle1", 0, 0, 32'h0,   64'h0, 0, 0, 64'h0);
    cyc("rd5",   1, 0, 32'h14,  64'h0, 1, 1, 64'h0);
    cyc("idle2", 0, 0, 32'h0,   64'h0, 0, 0, 64'h0);
    cyc("wr123", 1, 1, 32'h48C, 64'hDEADBEEF_CAFEF00D, 1, 0, 64'h0);
    cyc("rd123", 1, 0, 32'h48C, 64'h0, 1, 1, 64'hDEADBEEF_CAFEF00D);
    for (int i = 0; i < 4; i++)
      cyc($sformatf("wr%0d", i), 1, 1, 32'(i * 4), 64'(16 + i), 1, 0, 64'hDEADBEEF_CAFEF00D);
    for (int i = 0; i < 4; i++)
      cyc($sformatf("b2b_rd%0d", i), 1, 0, 32'(i * 4), 64'h0, 1, 1, 64'(16 + i));
    cyc("wr_alias",  1, 1, 32'h1004, 64'hA5A5A5A5, 1, 0, 64'h13);
    cyc("rd_alias",  1, 0, 32'h4,    64'h0, 1, 1, 64'hA5A5A5A5);
    cyc("rd_idx2",   1, 0, 32'h8,    64'h0, 1, 1, 64'h12);
    cyc("wr9",       1, 1, 32'h24,   64'h99, 1, 0, 64'h12);
    cyc("raw9",      1, 0, 32'h24,   64'h99, 1, 1, 64'h99);
    cyc("wr_oor",    1, 1, 32'hFA0,  64'h77, 1, 0, 64'h99);
    cyc("rd_oor",    1, 0, 32'hFA0,  64'h0, 1, 1, 64'h0);
    cyc("rd_oor_hi", 1, 0, 32'hFFC,  64'h0, 1, 1, 64'h0);
    cyc("rd9",       1, 0, 32'h24,   64'h0, 1, 1, 64'h99);
    cyc("wr7",       1, 1, 32'h1C,   64'h7777, 1, 0, 64'h99);
    cyc("idle_wr7a", 0, 0, 32'h0,    64'h0, 0, 0, 64'h99);
    cyc("idle_wr7b", 0, 0, 32'h0,    64'h0, 0, 0, 64'h99);
    cyc("rd7",       1, 0, 32'h1C,   64'h0, 1, 1, 64'h7777);
    @(negedge clk);
    #1 rst = 1'b1;
    #1 chk_out("async_rst", 1'b0, 1'b0, 64'h0);
    req = 1'b1; rw = 1'b1; addr = 32'h1C; wdata = 64'hBAD;
    @(posedge clk);
    #1 chk_out("rst_edge", 1'b0, 1'b0, 64'h0);
    req = 1'b0; rw = 1'b0;
    #2 rst = 1'b0;
    cyc("post_idle", 0, 0, 32'h0,  64'h0, 0, 0, 64'h0);
    cyc("post_rd7",  1, 0, 32'h1C, 64'h0, 1, 1, 64'h7777);
    cyc("post_rd0",  1, 0, 32'h0,  64'h0, 1, 1, 64'h10);
    cyc("post_rd5",  1, 0, 32'h14, 64'h0, 1, 1, 64'h0);
    cyc("post_idle2", 0, 0, 32'h0, 64'h0, 0, 0, 64'h0);
    repeat (3) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
